pipeline_debug_controller: RTL and testbench
============================================

Name: pipeline_debug_controller

Overview:
- Sequencer that owns the MIPS pipeline's execution enable and shares the register-file read port 1 between the decode stage and the debug interface.
- Accepts run / step / halt / dump commands from the debug link and gates the pipeline and PC update accordingly.
- Stops the pipeline when a HALT instruction retires.
- On a dump command, walks every register through the shared read port and streams the contents out with a valid/ready handshake.

Parameters:
- NREGS, 32, number of register-file entries dumped (index 0..NREGS-1).
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NREGS.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  debug command present.
- cmd_op  in  2  00=halt, 01=run, 10=step, 11=dump.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- halt_retired  in  1  HALT instruction reached write-back this cycle.
- pipe_en  out  1  enables PC, pipeline registers and register-file writes.
- rf_sel_dbg  out  1  1 = register-file read port 1 address comes from rf_addr_dbg instead of decode.
- rf_addr_dbg  out  ADDR_W  debug read address.
- rf_rd_data  in  DATA_W  register-file read port 1 data (combinational read).
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  consumer accepts word.
- dump_data  out  DATA_W  register contents.
- dump_idx  out  ADDR_W  register index of dump_data.
- dump_last  out  1  current word is index NREGS-1.
- halted  out  1  sticky flag: HALT instruction has retired.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, RUN, STEP, DUMP_RD, DUMP_TX. All outputs are registered except cmd_ready and busy, which are decoded from state.
- Reset (asynchronous, any state, including mid-dump):
  - state=IDLE; pipe_en=0, rf_sel_dbg=0, rf_addr_dbg=0.
  - dump_valid=0, dump_data=0, dump_idx=0, dump_last=0, halted=0.
  - Any in-progress dump is discarded and not resumed.
- cmd_ready=1 in IDLE and RUN, 0 otherwise.
- IDLE:
  - run accepted and halted=0 -> RUN; pipe_en=1 from the next cycle.
  - step accepted and halted=0 -> STEP.
  - run or step accepted while halted=1: command is consumed with no effect; state stays IDLE.
  - halt accepted: no effect.
  - dump accepted -> DUMP_RD with rf_addr_dbg=0, rf_sel_dbg=1.
- RUN:
  - pipe_en held 1.
  - halt command accepted, or halt_retired=1 -> IDLE, pipe_en=0 on the next edge.
  - halt_retired also sets halted=1. If both occur in the same cycle, the result is the same single transition with halted=1.
  - run, step or dump in RUN are consumed and ignored.
- STEP:
  - pipe_en=1 for exactly one cycle, then IDLE with pipe_en=0.
  - halt_retired during that cycle sets halted=1.
- DUMP_RD:
  - rf_rd_data is sampled into dump_data and dump_idx is loaded from rf_addr_dbg.
  - dump_last is set if rf_addr_dbg==NREGS-1.
  - dump_valid is set to 1 -> DUMP_TX.
- DUMP_TX:
  - dump_data, dump_idx and dump_last are held stable while dump_valid=1 and dump_ready=0.
  - On a handshake with dump_last=0: dump_valid=0, rf_addr_dbg increments by 1 -> DUMP_RD.
  - On a handshake with dump_last=1: dump_valid=0, rf_sel_dbg=0, rf_addr_dbg=0 -> IDLE.
- Dump timing:
  - Throughput is at most 1 word per 2 cycles.
  - Latency from dump command acceptance to the first dump_valid is 2 cycles.
  - pipe_en stays 0 throughout a dump, so the register file cannot change mid-dump.
- Counter rule: rf_addr_dbg never exceeds NREGS-1 and does not wrap.
- halted clears only on rst.

Test Plan:
- Reset then run: cmd run at cycle N -> pipe_en=1 from N+1. Assert halt_retired at N+5 -> pipe_en=0 at N+6, halted=1, state IDLE. A later run command is consumed and pipe_en stays 0.
- Step: three consecutive step commands from IDLE -> exactly three single-cycle pipe_en pulses, IDLE after each.
- Halt in RUN coinciding with halt_retired in the same cycle -> one transition to IDLE, halted=1, pipe_en=0 next cycle.
- Dump with dump_ready=1 and register model r[i]=0x1000+i -> 32 words, idx 0..31 with data 0x1000..0x101F, dump_last only on idx 31, rf_sel_dbg=0 afterwards.
- Dump backpressure: hold dump_ready=0 for 10 cycles on idx 5 -> dump_data=0x1005 and dump_idx=5 stay stable; no skipped or duplicated index after release.
- Assert rst during DUMP_TX at idx 12 -> all outputs return to reset values immediately. A new dump restarts at idx 0.

Source files
------------

// File: rtl/pipeline_debug_controller_if.sv
// Debug-link bundle: command channel into the controller and register-dump stream out of it.
// The controller is the slave and the debug host is the master.
interface pipeline_debug_controller_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic              cmd_ready;
  logic              dump_valid;
  logic              dump_ready;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_idx;
  logic              dump_last;

  modport master (
    output cmd_valid, cmd_op, dump_ready,
    input  cmd_ready, dump_valid, dump_data, dump_idx, dump_last
  );

  modport slave (
    input  cmd_valid, cmd_op, dump_ready,
    output cmd_ready, dump_valid, dump_data, dump_idx, dump_last
  );
endinterface

// File: rtl/pipeline_debug_controller.sv
// Run/step/halt sequencer for the MIPS pipeline that also streams out the register file,
// borrowing register-file read port 1 from decode while a dump is in progress.
module pipeline_debug_controller #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_debug_controller_if.slave dbg,
  input  logic                  halt_retired,
  output logic                  pipe_en,
  output logic                  rf_sel_dbg,
  output logic [ADDR_W-1:0]     rf_addr_dbg,
  input  logic [DATA_W-1:0]     rf_rd_data,
  output logic                  halted,
  output logic                  busy
);

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DUMP_RD,
    DUMP_TX
  } state_t;

  state_t state, stateNext;

  logic              dumpValid, dumpValidNext;
  logic [DATA_W-1:0] dumpData, dumpDataNext;
  logic [ADDR_W-1:0] dumpIdx, dumpIdxNext;
  logic              dumpLast, dumpLastNext;
  logic              pipeEnNext, selNext, haltedNext;
  logic [ADDR_W-1:0] addrNext;
  logic              cmdFire, dumpFire;

  assign dbg.cmd_ready  = (state == IDLE) || (state == RUN);
  assign busy           = (state != IDLE);
  assign dbg.dump_valid = dumpValid;
  assign dbg.dump_data  = dumpData;
  assign dbg.dump_idx   = dumpIdx;
  assign dbg.dump_last  = dumpLast;

  assign cmdFire  = dbg.cmd_valid && dbg.cmd_ready;
  assign dumpFire = dumpValid && dbg.dump_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext     = state;
    pipeEnNext    = pipe_en;
    selNext       = rf_sel_dbg;
    addrNext      = rf_addr_dbg;
    haltedNext    = halted;
    dumpValidNext = dumpValid;
    dumpDataNext  = dumpData;
    dumpIdxNext   = dumpIdx;
    dumpLastNext  = dumpLast;

    case (state)
      IDLE: begin
        pipeEnNext = 1'b0;
        if (cmdFire) begin
          case (dbg.cmd_op)
            OP_RUN: if (!halted) begin
              stateNext  = RUN;
              pipeEnNext = 1'b1;
            end
            OP_STEP: if (!halted) begin
              stateNext  = STEP;
              pipeEnNext = 1'b1;
            end
            OP_DUMP: begin
              stateNext = DUMP_RD;
              selNext   = 1'b1;
              addrNext  = '0;
            end
            default: ;
          endcase
        end
      end

      RUN: begin
        pipeEnNext = 1'b1;
        if (halt_retired) haltedNext = 1'b1;
        if (halt_retired || (cmdFire && dbg.cmd_op == OP_HALT)) begin
          stateNext  = IDLE;
          pipeEnNext = 1'b0;
        end
      end

      // Single enabled cycle; the pipeline is frozen again from the next edge.
      STEP: begin
        pipeEnNext = 1'b0;
        stateNext  = IDLE;
        if (halt_retired) haltedNext = 1'b1;
      end

      DUMP_RD: begin
        dumpDataNext  = rf_rd_data;
        dumpIdxNext   = rf_addr_dbg;
        dumpLastNext  = (rf_addr_dbg == LAST_ADDR);
        dumpValidNext = 1'b1;
        stateNext     = DUMP_TX;
      end

      // Word is held until accepted; the last word hands the read port back to decode.
      DUMP_TX: begin
        if (dumpFire) begin
          dumpValidNext = 1'b0;
          if (dumpLast) begin
            selNext   = 1'b0;
            addrNext  = '0;
            stateNext = IDLE;
          end else begin
            addrNext  = rf_addr_dbg + 1'b1;
            stateNext = DUMP_RD;
          end
        end
      end

      default: begin
        stateNext  = IDLE;
        pipeEnNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_en     <= 1'b0;
      rf_sel_dbg  <= 1'b0;
      rf_addr_dbg <= '0;
      halted      <= 1'b0;
      dumpValid   <= 1'b0;
      dumpData    <= '0;
      dumpIdx     <= '0;
      dumpLast    <= 1'b0;
    end else begin
      pipe_en     <= pipeEnNext;
      rf_sel_dbg  <= selNext;
      rf_addr_dbg <= addrNext;
      halted      <= haltedNext;
      dumpValid   <= dumpValidNext;
      dumpData    <= dumpDataNext;
      dumpIdx     <= dumpIdxNext;
      dumpLast    <= dumpLastNext;
    end
  end

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Bench for pipeline_debug_controller: directed control sequences plus a scoreboard
// that checks every dump word the controller hands over.
module tb_pipeline_debug_controller;

  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              halt_retired;
  logic              pipe_en;
  logic              rf_sel_dbg;
  logic [ADDR_W-1:0] rf_addr_dbg;
  logic [DATA_W-1:0] rf_rd_data;
  logic              halted;
  logic              busy;

  pipeline_debug_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg ();

  pipeline_debug_controller #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .dbg          (dbg.slave),
    .halt_retired (halt_retired),
    .pipe_en      (pipe_en),
    .rf_sel_dbg   (rf_sel_dbg),
    .rf_addr_dbg  (rf_addr_dbg),
    .rf_rd_data   (rf_rd_data),
    .halted       (halted),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Register file model r[i] = 0x1000 + i, visible only when the debug address is selected.
  assign rf_rd_data = rf_sel_dbg ? (32'h1000 + 32'(rf_addr_dbg)) : 32'hDEAD_BEEF;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } word_t;

  word_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushDump();
    word_t w;
    for (int i = 0; i < NREGS; i++) begin
      w.idx  = ADDR_W'(i);
      w.data = 32'h1000 + i;
      w.last = (i == NREGS - 1);
      q.push_back(w);
    end
  endtask

  task automatic sendCmd(input logic [1:0] op);
    dbg.cmd_valid = 1'b1;
    dbg.cmd_op    = op;
    tick();
    dbg.cmd_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (q.size() != 0) check({name, "_timeout"}, 64'(q.size()), 64'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every accepted dump word must match the head of the scoreboard.
  always @(negedge clk) begin
    word_t wm;
    if (!rst && dbg.dump_valid && dbg.dump_ready) begin
      if (q.size() == 0) begin
        check("dump_extra_word", 64'(dbg.dump_idx), 64'hFFFF);
      end else begin
        wm = q.pop_front();
        check("dump_idx",  64'(dbg.dump_idx),  64'(wm.idx));
        check("dump_data", 64'(dbg.dump_data), 64'(wm.data));
        check("dump_last", 64'(dbg.dump_last), 64'(wm.last));
      end
    end
  end

  initial begin
    bit held;
    int n;
    rst            = 1'b1;
    halt_retired   = 1'b0;
    dbg.cmd_valid  = 1'b0;
    dbg.cmd_op     = 2'b00;
    dbg.dump_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_pipe_en", 64'(pipe_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(dbg.cmd_ready), 64'd1);
    check("rst_dump_valid", 64'(dbg.dump_valid), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);

    // Three steps: one enabled cycle each, back in IDLE after each.
    for (int i = 0; i < 3; i++) begin
      sendCmd(2'b10);
      check("step_pipe_en_hi", 64'(pipe_en), 64'd1);
      check("step_cmd_ready", 64'(dbg.cmd_ready), 64'd0);
      tick();
      check("step_pipe_en_lo", 64'(pipe_en), 64'd0);
      check("step_idle", 64'(busy), 64'd0);
    end

    // Run stopped by a halt command leaves halted clear.
    sendCmd(2'b01);
    check("run_pipe_en", 64'(pipe_en), 64'd1);
    sendCmd(2'b00);
    check("haltcmd_pipe_en", 64'(pipe_en), 64'd0);
    check("haltcmd_halted", 64'(halted), 64'd0);

    // Run stopped by HALT retiring, later run consumed without effect.
    sendCmd(2'b01);
    check("run2_pipe_en", 64'(pipe_en), 64'd1);
    sendCmd(2'b11);
    check("run_ignores_dump", 64'(pipe_en), 64'd1);
    tick();
    tick();
    check("run2_hold", 64'(pipe_en), 64'd1);
    halt_retired = 1'b1;
    tick();
    halt_retired = 1'b0;
    check("retire_pipe_en", 64'(pipe_en), 64'd0);
    check("retire_halted", 64'(halted), 64'd1);
    check("retire_idle", 64'(busy), 64'd0);
    sendCmd(2'b01);
    check("halted_run_pipe_en", 64'(pipe_en), 64'd0);
    check("halted_run_idle", 64'(busy), 64'd0);
    sendCmd(2'b10);
    check("halted_step_pipe_en", 64'(pipe_en), 64'd0);

    // Halt command and HALT retirement in the same cycle.
    doReset();
    check("rst_clears_halted", 64'(halted), 64'd0);
    sendCmd(2'b01);
    dbg.cmd_valid = 1'b1;
    dbg.cmd_op    = 2'b00;
    halt_retired  = 1'b1;
    tick();
    dbg.cmd_valid = 1'b0;
    halt_retired  = 1'b0;
    check("both_pipe_en", 64'(pipe_en), 64'd0);
    check("both_halted", 64'(halted), 64'd1);
    check("both_idle", 64'(busy), 64'd0);
    tick();
    check("both_stay_idle", 64'(busy), 64'd0);

    // Full dump with the consumer always ready.
    pushDump();
    sendCmd(2'b11);
    check("dump_sel", 64'(rf_sel_dbg), 64'd1);
    check("dump_lat1_valid", 64'(dbg.dump_valid), 64'd0);
    check("dump_pipe_en", 64'(pipe_en), 64'd0);
    tick();
    check("dump_lat2_valid", 64'(dbg.dump_valid), 64'd1);
    waitDrain("dump_full", 200);
    check("dump_end_sel", 64'(rf_sel_dbg), 64'd0);
    check("dump_end_addr", 64'(rf_addr_dbg), 64'd0);
    check("dump_end_idle", 64'(busy), 64'd0);

    // Backpressure on idx 5 for 10 cycles.
    pushDump();
    sendCmd(2'b11);
    held = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      if (!held && dbg.dump_valid && dbg.dump_idx == 5) begin
        dbg.dump_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
          tick();
          check("bp_valid", 64'(dbg.dump_valid), 64'd1);
          check("bp_data", 64'(dbg.dump_data), 64'h1005);
          check("bp_idx", 64'(dbg.dump_idx), 64'd5);
        end
        dbg.dump_ready = 1'b1;
        held = 1'b1;
      end
      tick();
      n++;
    end
    if (q.size() != 0) check("bp_timeout", 64'(q.size()), 64'd0);
    check("bp_seen_idx5", 64'(held), 64'd1);

    // Reset while word 12 is waiting for the consumer.
    pushDump();
    sendCmd(2'b11);
    n = 0;
    while (!(dbg.dump_valid && dbg.dump_idx == 12) && n < 100) begin
      tick();
      n++;
    end
    dbg.dump_ready = 1'b0;
    check("rst12_reached", 64'(dbg.dump_idx), 64'd12);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst12_dump_valid", 64'(dbg.dump_valid), 64'd0);
    check("rst12_dump_idx", 64'(dbg.dump_idx), 64'd0);
    check("rst12_dump_data", 64'(dbg.dump_data), 64'd0);
    check("rst12_sel", 64'(rf_sel_dbg), 64'd0);
    check("rst12_addr", 64'(rf_addr_dbg), 64'd0);
    check("rst12_busy", 64'(busy), 64'd0);
    check("rst12_halted", 64'(halted), 64'd0);
    q.delete();
    tick();
    rst = 1'b0;
    dbg.dump_ready = 1'b1;
    tick();
    check("rst12_stay_idle", 64'(busy), 64'd0);

    // Fresh dump after the interrupted one starts at index 0.
    pushDump();
    sendCmd(2'b11);
    waitDrain("dump_restart", 200);
    check("restart_end_sel", 64'(rf_sel_dbg), 64'd0);
    check("sb_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
